lut_grid_renderer: RTL

- Pixel-stage renderer directly downstream of the video timing generator.
- Consumes hs/vs/de and active_x/active_y, and draws a GRID_COLS x GRID_ROWS array of LUT-network cell states as coloured squares with grid lines.
- Cell states are written by the host into a double-buffered bit map; the banks swap only at a frame boundary.
- Outputs RGB plus hs/vs/de, delayed so that all of them stay aligned for the HDMI/LCD encoder.

---
 rtl/lut_grid_renderer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lut_grid_renderer.sv
// Pixel-stage renderer: draws a double-buffered grid of cell bits as coloured squares
// with grid lines. Fixed 3-cycle latency on rgb/hs/vs/de, and banks swap only at frame start.
module lut_grid_renderer #(
  parameter logic [12:0] ORIGIN_X  = 13'd64,
  parameter logic [12:0] ORIGIN_Y  = 13'd32,
  parameter int unsigned CELL_LOG2 = 5,
  parameter int unsigned GRID_COLS = 16,
  parameter int unsigned GRID_ROWS = 16,
  parameter logic        VS_POL    = 1'b1,
  parameter logic [23:0] COL_ON    = 24'hFFA000,
  parameter logic [23:0] COL_OFF   = 24'h202020,
  parameter logic [23:0] COL_LINE  = 24'h808080,
  parameter logic [23:0] COL_BG    = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        de_in,
  input  logic [12:0] active_x,
  input  logic [12:0] active_y,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic        wr_data,
  input  logic        commit,
  output logic        wr_ready,
  output logic        swap_pending,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out,
  output logic [23:0] rgb,
  output logic [15:0] frame_cnt
);

  localparam int unsigned COL_BITS  = $clog2(GRID_COLS);
  localparam int unsigned ROW_BITS  = $clog2(GRID_ROWS);
  localparam int unsigned ADDR_BITS = COL_BITS + ROW_BITS;
  localparam int unsigned CELLS     = GRID_COLS * GRID_ROWS;

  typedef enum logic {IDLE, PENDING} swap_state_e;

  swap_state_e state_q, state_d;
  logic        swap_toggle;
  logic        front_sel_q;
  logic [CELLS-1:0] bank0_q, bank1_q, front_bits;
  logic [15:0] frame_cnt_q;

  // Stage registers
  logic hs1_q, vs1_q, de1_q, in_grid1_q, lx1_q, ly1_q;
  logic [COL_BITS-1:0] col1_q;
  logic [ROW_BITS-1:0] row1_q;
  logic hs2_q, vs2_q, de2_q, in_grid2_q, line2_q, bit2_q;
  logic hs3_q, vs3_q, de3_q;
  logic [23:0] rgb3_q, rgb_d;

  logic [12:0] dx, dy, cx, cy;
  logic        in_grid_d, frame_start;
  logic        wr_in_range, wr_fire;
  logic [ADDR_BITS-1:0] wr_idx, rd_idx;

  assign dx = active_x - ORIGIN_X;
  assign dy = active_y - ORIGIN_Y;
  assign cx = dx >> CELL_LOG2;
  assign cy = dy >> CELL_LOG2;
  assign in_grid_d = de_in && (active_x >= ORIGIN_X) && (active_y >= ORIGIN_Y) &&
                     (cx < 13'(GRID_COLS)) && (cy < 13'(GRID_ROWS));

  // vs1_q holds the previous cycle's vs_in, so the edge is detected on the S1 sample
  assign frame_start = (vs_in == VS_POL) && (vs1_q != VS_POL);

  assign swap_pending = (state_q == PENDING);
  assign wr_ready     = ~swap_pending;
  assign wr_in_range  = (wr_addr >> ADDR_BITS) == 8'd0;
  assign wr_fire      = wr_en && wr_ready && wr_in_range;
  assign wr_idx       = wr_addr[ADDR_BITS-1:0];

  assign rd_idx     = {row1_q, col1_q};
  assign front_bits = front_sel_q ? bank1_q : bank0_q;

  always_comb begin
    state_d     = state_q;
    swap_toggle = 1'b0;
    unique case (state_q)
      IDLE:    if (commit) state_d = PENDING;
      PENDING: if (frame_start) begin
        state_d     = IDLE;
        swap_toggle = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      front_sel_q <= 1'b0;
      frame_cnt_q <= '0;
      bank0_q     <= '0;
      bank1_q     <= '0;
    end else begin
      state_q <= state_d;
      if (swap_toggle) front_sel_q <= ~front_sel_q;
      if (frame_start) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (wr_fire && front_sel_q)  bank0_q[wr_idx] <= wr_data;
      if (wr_fire && !front_sel_q) bank1_q[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rgb_d = '0;
    if (!de2_q)           rgb_d = '0;
    else if (!in_grid2_q) rgb_d = COL_BG;
    else if (line2_q)     rgb_d = COL_LINE;
    else if (bit2_q)      rgb_d = COL_ON;
    else                  rgb_d = COL_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {hs1_q, vs1_q, de1_q, in_grid1_q, lx1_q, ly1_q} <= '0;
      col1_q <= '0;
      row1_q <= '0;
      {hs2_q, vs2_q, de2_q, in_grid2_q, line2_q, bit2_q} <= '0;
      {hs3_q, vs3_q, de3_q} <= '0;
      rgb3_q <= '0;
    end else begin
      hs1_q      <= hs_in;
      vs1_q      <= vs_in;
      de1_q      <= de_in;
      in_grid1_q <= in_grid_d;
      lx1_q      <= (dx[CELL_LOG2-1:0] == '0);
      ly1_q      <= (dy[CELL_LOG2-1:0] == '0);
      col1_q     <= cx[COL_BITS-1:0];
      row1_q     <= cy[ROW_BITS-1:0];

      hs2_q      <= hs1_q;
      vs2_q      <= vs1_q;
      de2_q      <= de1_q;
      in_grid2_q <= in_grid1_q;
      line2_q    <= lx1_q || ly1_q;
      bit2_q     <= front_bits[rd_idx];

      hs3_q      <= hs2_q;
      vs3_q      <= vs2_q;
      de3_q      <= de2_q;
      rgb3_q     <= rgb_d;
    end
  end

  assign hs_out    = hs3_q;
  assign vs_out    = vs3_q;
  assign de_out    = de3_q;
  assign rgb       = rgb3_q;
  assign frame_cnt = frame_cnt_q;

endmodule
